fpu_result_buffer: RTL
======================

FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
- REQ-001 SHALL have parameter Width, default 64: result payload width in bits.
- REQ-002 SHALL have parameter Depth, default 4: number of entries; power of two, at least 2.
- REQ-003 SHALL have parameter TagWidth, default 1: tag width in bits.
- REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
- REQ-006 SHALL have port in_valid_i, input, 1: the FPU presents a result; connects to fpnew out_valid_o.
- REQ-007 SHALL have port in_ready_o, output, 1: the buffer accepts a result; connects to fpnew out_ready_i.
- REQ-008 SHALL have port result_i, input, Width: FPU result.
- REQ-009 SHALL have port status_i, input, 5: fpnew_pkg::status_t, bit order {NV,DZ,OF,UF,NX}.
- REQ-010 SHALL have port tag_i, input, TagWidth: FPU tag.
- REQ-011 SHALL have port flush_i, input, 1: discard all buffered entries.
- REQ-012 SHALL have port wb_valid_o, output, 1: the head entry is valid for writeback.
- REQ-013 SHALL have port wb_ready_i, input, 1: the writeback consumer accepts the head entry.
- REQ-014 SHALL have ports wb_result_o (Width), wb_status_o (5) and wb_tag_o (TagWidth), all outputs: the head-entry fields.
- REQ-015 SHALL have port count_o, output, $clog2(Depth)+1: current occupancy.
- REQ-016 SHALL have ports fflags_o (output, 5) and fflags_clr_i (input, 1), present only when FPU_RESULT_FFLAGS_EN is defined.

Function
- REQ-017 SHALL define push = in_valid_i & in_ready_o and pop = wb_valid_o & wb_ready_i.
- REQ-018 SHALL drive in_ready_o = (count_o != Depth); it does not depend on wb_ready_i, so there is no pass-through when full.
- REQ-019 SHALL drive wb_valid_o = (count_o != 0); there is no bypass, so a push in cycle N is visible at the head in cycle N+1 at the earliest.
- REQ-020 SHALL hold the wb_* outputs stable while wb_valid_o=1 and wb_ready_i=0.
- REQ-021 SHALL perform push and pop in the same cycle when the buffer is non-empty and non-full; count is then unchanged.
- REQ-022 SHALL deliver entries in FIFO order, with read and write pointers wrapping modulo Depth.
- REQ-023 SHALL, on flush_i=1, set count to 0 and reset both pointers at the next edge.
- REQ-024 SHALL give flush_i priority over a simultaneous push or pop; both are dropped.
- REQ-025 SHALL drive wb_result_o, wb_status_o and wb_tag_o to 0 when the buffer is empty.

Reset
- REQ-026 SHALL, on asserting rst_ni=0 (at any time, including mid-transfer), immediately clear count_o, both pointers, wb_valid_o and fflags_o.
- REQ-027 SHALL, while in reset, drive in_ready_o=1 and all wb_* data outputs to 0; storage contents need no reset.

Configuration
- REQ-028 SHALL, when FPU_RESULT_FFLAGS_EN is defined, include a sticky flag register with next value = (fflags_clr_i ? 0 : fflags) | (push ? status_i : 0).
- REQ-029 SHALL make a clear and a push in the same cycle leave exactly the pushed flags set.
- REQ-030 SHALL leave fflags unaffected by flush_i.
- REQ-031 SHALL, when FPU_RESULT_FFLAGS_EN is undefined, omit both fflags ports and the flag register; FIFO behaviour is identical in both builds.

Structure
- REQ-032 SHALL take status_t from fpnew_pkg.
- REQ-033 SHALL place an entry struct rb_entry_t {result, status, tag} and the default-depth constant in a shared package fpu_rb_pkg.
- REQ-034 SHALL implement the sticky flag logic as one sub-module, fpu_fflags_acc, instantiated only under FPU_RESULT_FFLAGS_EN.

Verification
- REQ-035 SHALL cover: push result 0x40000000 (1.0+1.0 FP32), status 0x00, tag 1, wb_ready_i=1 -> wb_valid_o=1 exactly one cycle later with that result and tag 1, then count_o returns to 0.
- REQ-036 SHALL cover: 5 back-to-back pushes with wb_ready_i=0 -> count_o=4, in_ready_o=0, 5th result held by the source; one pop -> 5th result accepted next cycle, order preserved.
- REQ-037 SHALL cover: continuous push and pop for 10 cycles with count_o=2 -> count_o stays 2 and pointers wrap without loss.
- REQ-038 SHALL cover: 3 entries buffered, assert flush_i together with a push -> count_o=0 and wb_valid_o=0 the next cycle; the pushed entry is never delivered.
- REQ-039 SHALL cover (flags build): push status 0x01 then 0x04 -> fflags_o=0x05; fflags_clr_i together with a push of 0x08 -> fflags_o=0x08.
- REQ-040 SHALL cover: rst_ni pulled low mid-cycle with 2 entries buffered -> wb_valid_o=0 and count_o=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Minimal fpnew package subset: the floating-point exception status word
// produced alongside every FPU result, bit order {NV,DZ,OF,UF,NX}.
package fpnew_pkg;

  typedef struct packed {
    logic NV;  // invalid operation
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

endpackage

// File: rtl/fpu_rb_pkg.sv
// Shared definitions for the FPU result buffer: the buffered entry layout
// and the default depth. The entry fields are sized for the widest result
// and tag the buffer supports (Width <= 128, TagWidth <= 16); narrower
// configurations zero-extend on write and truncate on read.
package fpu_rb_pkg;

  localparam int unsigned DefaultDepth  = 4;
  localparam int unsigned RbMaxWidth    = 128;
  localparam int unsigned RbMaxTagWidth = 16;

  typedef struct packed {
    logic [RbMaxWidth-1:0]    result;
    fpnew_pkg::status_t       status;
    logic [RbMaxTagWidth-1:0] tag;
  } rb_entry_t;

endpackage

// File: rtl/fpu_fflags_acc.sv
// Sticky floating-point exception flag accumulator. Every accepted result
// ORs its status into the register; a clear in the same cycle as a push
// leaves exactly the pushed flags set.
module fpu_fflags_acc (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  fpnew_pkg::status_t status_i,
  input  logic               clr_i,
  output fpnew_pkg::status_t fflags_o
);

  fpnew_pkg::status_t flags_q;
  fpnew_pkg::status_t flags_d;

  // Next value: optionally cleared history, plus the flags of this push.
  always_comb begin
    flags_d = clr_i ? '0 : flags_q;
    if (push_i) flags_d = flags_d | status_i;
  end

  // Flag register, cleared asynchronously by reset only (flush keeps it).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign fflags_o = flags_q;

endmodule

// File: rtl/fpu_result_buffer.sv
// FPU result buffer: a Depth-entry FIFO between the fpnew output handshake
// and the writeback stage. No bypass (a result is visible at the head one
// cycle after it is accepted) and no pass-through when full.
// Optional build macro FPU_RESULT_FFLAGS_EN adds a sticky exception flag
// register with ports fflags_o / fflags_clr_i.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready_o depends only on occupancy; wb_valid_o depends only on
// occupancy and the wb_* fields stay stable while wb_valid_o=1, wb_ready_i=0.
module fpu_result_buffer
  import fpu_rb_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = DefaultDepth,
  parameter int unsigned TagWidth = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [Width-1:0]       result_i,
  input  logic [4:0]             status_i,
  input  logic [TagWidth-1:0]    tag_i,
  input  logic                   flush_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [Width-1:0]       wb_result_o,
  output logic [4:0]             wb_status_o,
  output logic [TagWidth-1:0]    wb_tag_o,
  output logic [$clog2(Depth):0] count_o
`ifdef FPU_RESULT_FFLAGS_EN
  ,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_clr_i
`endif
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            push;
  logic            pop;
  rb_entry_t       wr_entry;
  rb_entry_t       mem [Depth];

  assign in_ready_o = (count != CntW'(Depth));
  assign wb_valid_o = (count != '0);
  assign push       = in_valid_i & in_ready_o;
  assign pop        = wb_valid_o & wb_ready_i;
  assign count_o    = count;

  // Pack the incoming result into the widest entry layout.
  always_comb begin
    wr_entry        = '0;
    wr_entry.result = RbMaxWidth'(result_i);
    wr_entry.status = fpnew_pkg::status_t'(status_i);
    wr_entry.tag    = RbMaxTagWidth'(tag_i);
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= wr_entry;
  end

  // Pointers and occupancy; flush wins over any simultaneous push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head fields, forced to zero while empty (also covers reset).
  assign wb_result_o = wb_valid_o ? Width'(mem[rd_ptr].result) : '0;
  assign wb_status_o = wb_valid_o ? mem[rd_ptr].status : '0;
  assign wb_tag_o    = wb_valid_o ? TagWidth'(mem[rd_ptr].tag) : '0;

`ifdef FPU_RESULT_FFLAGS_EN
  fpu_fflags_acc u_fflags (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push),
    .status_i (fpnew_pkg::status_t'(status_i)),
    .clr_i    (fflags_clr_i),
    .fflags_o (fflags_o)
  );
`endif

endmodule
